cdc_msg_arbiter: RTL and testbench

// - Shares one cdc_reqack_bus channel (W = IDW+DW) between N source-domain requesters.
// - Each requester owns a 1-deep holding slot. A round-robin arbiter tags the chosen message

---
 rtl/cdc_msg_arbiter_if.sv | 29 ++
 rtl/cdc_msg_arbiter.sv | 122 ++++++++++++
 tb/tb_cdc_msg_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_msg_arbiter_if.sv
// Requester-side and channel-side signals of the CDC message arbiter.
// The slave modport is the arbiter; the master modport is requesters plus the bus.
interface cdc_msg_arbiter_if #(
    parameter int unsigned N   = 4,
    parameter int unsigned DW  = 6,
    parameter int unsigned IDW = 2
);
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      done;
    logic              cdc_send;
    logic [IDW+DW-1:0] cdc_data;
    logic              cdc_busy;
    logic [IDW-1:0]    active_id;
    logic              err_timeout;
    logic              err_clr;
    logic [15:0]       msg_count;

    modport slave (
        input  req_valid, req_data, cdc_busy, err_clr,
        output req_ready, done, cdc_send, cdc_data, active_id, err_timeout, msg_count
    );

    modport master (
        output req_valid, req_data, cdc_busy, err_clr,
        input  req_ready, done, cdc_send, cdc_data, active_id, err_timeout, msg_count
    );
endinterface

// File: rtl/cdc_msg_arbiter.sv
// Round-robin sharing of one req/ack CDC channel between N requesters with 1-deep slots.
// Tags each message with its requester ID and waits out the full busy round trip.
module cdc_msg_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned DW      = 6,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               src_clk,
    input  logic               src_rst,
    cdc_msg_arbiter_if.slave   bus
);
    localparam int unsigned W        = IDW + DW;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT);
    localparam logic [15:0] TMO_SET  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        BUSY
    } state_t;

    state_t          state;
    logic [N-1:0]    slot_full;
    logic [DW-1:0]   slot_data [N];
    logic [IDW-1:0]  rr;
    logic [IDW-1:0]  active_id_r;
    logic [N-1:0]    done_r;
    logic            send_r;
    logic [W-1:0]    data_r;
    logic            err_r;
    logic [15:0]     msg_count_r;
    logic [15:0]     tmo_cnt;

    logic [N-1:0]    accept;
    logic            grant_any;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  cand;

    assign accept = bus.req_valid & ~slot_full;

    // First full slot after the last grant, wrapping modulo N
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDW'((32'(rr) + k) % N);
            if (!grant_any && slot_full[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            state       <= IDLE;
            slot_full   <= '0;
            for (int i = 0; i < int'(N); i++) slot_data[i] <= '0;
            rr          <= IDW'(N - 1);
            active_id_r <= '0;
            done_r      <= '0;
            send_r      <= 1'b0;
            data_r      <= '0;
            err_r       <= 1'b0;
            msg_count_r <= '0;
            tmo_cnt     <= '0;
        end else begin
            done_r <= '0;
            send_r <= 1'b0;

            for (int i = 0; i < int'(N); i++) begin
                if (accept[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_data[i] <= bus.req_data[i*DW +: DW];
                end
            end

            if (bus.err_clr) err_r <= 1'b0;

            // Round-trip watchdog; only flags, the transfer itself is never dropped
            if (state != IDLE) begin
                if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 16'd1;
                if (tmo_cnt == TMO_SET) err_r <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_any && !bus.cdc_busy) begin
                        send_r              <= 1'b1;
                        data_r              <= {grant_id, slot_data[grant_id]};
                        active_id_r         <= grant_id;
                        rr                  <= grant_id;
                        slot_full[grant_id] <= 1'b0;
                        tmo_cnt             <= '0;
                        state               <= ARMED;
                    end
                end
                ARMED: begin
                    if (bus.cdc_busy) state <= BUSY;
                end
                BUSY: begin
                    if (!bus.cdc_busy) begin
                        done_r[active_id_r] <= 1'b1;
                        msg_count_r         <= msg_count_r + 16'd1;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = ~slot_full;
    assign bus.done        = done_r;
    assign bus.cdc_send    = send_r;
    assign bus.cdc_data    = data_r;
    assign bus.active_id   = active_id_r;
    assign bus.err_timeout = err_r;
    assign bus.msg_count   = msg_count_r;
endmodule

// File: tb/tb_cdc_msg_arbiter.sv
// Scoreboard bench for cdc_msg_arbiter: directed scenarios plus randomized traffic,
// checked against a slot/round-robin reference model and a simple req/ack bus model.
module tb_cdc_msg_arbiter;
    localparam int unsigned N       = 4;
    localparam int unsigned DW      = 6;
    localparam int unsigned IDW     = 2;
    localparam int unsigned TIMEOUT = 255;
    typedef logic [IDW+DW-1:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdc_msg_arbiter_if #(.N(N), .DW(DW), .IDW(IDW)) bus_if ();

    cdc_msg_arbiter #(.N(N), .DW(DW), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .src_clk (clk),
        .src_rst (rst),
        .bus     (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [N-1:0]  model_full, incoming;
    logic [DW-1:0] model_data [N];
    logic [DW-1:0] inc_data [N];
    int            last_gnt;
    bit            outstanding;
    word_t         last_word;
    logic [IDW-1:0] last_act;
    logic [15:0]   acks;
    int            done_q[$];
    word_t         send_log[$];

    // Stimulus control
    bit            mon_en, drive_en, bus_manual, man_busy;
    int            bus_hold;
    logic [N-1:0]  dir_valid;
    logic [N*DW-1:0] dir_data;
    logic [N-1:0]  drv_v;
    logic [DW-1:0] drv_d;
    int            bus_phase, bus_cnt;
    int            m_eid, m_c;
    bit            m_found;
    word_t         rr_exp [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_full  = '0;
        incoming    = '0;
        last_gnt    = N - 1;
        outstanding = 1'b0;
        last_word   = '0;
        last_act    = '0;
        acks        = '0;
        done_q.delete();
        send_log.delete();
    endtask

    // Monitor: predicts each grant from the model slots and checks every DUT output
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus_if.cdc_send === 1'b1) begin
                m_found = 1'b0;
                m_eid   = 0;
                for (int k = 1; k <= int'(N); k++) begin
                    m_c = (last_gnt + k) % N;
                    if (!m_found && model_full[m_c]) begin
                        m_found = 1'b1;
                        m_eid   = m_c;
                    end
                end
                chk("send_while_outstanding", 32'(outstanding), 32'd0);
                if (!m_found) begin
                    chk("unexpected_send", 32'd1, 32'd0);
                end else begin
                    chk("send_data", 32'(bus_if.cdc_data), 32'({IDW'(m_eid), model_data[m_eid]}));
                    chk("send_active_id", 32'(bus_if.active_id), 32'(m_eid));
                    model_full[m_eid] = 1'b0;
                    last_gnt    = m_eid;
                    outstanding = 1'b1;
                    last_word   = {IDW'(m_eid), model_data[m_eid]};
                    last_act    = IDW'(m_eid);
                    done_q.push_back(m_eid);
                    send_log.push_back(bus_if.cdc_data);
                end
            end else begin
                chk("data_hold", 32'(bus_if.cdc_data), 32'(last_word));
                chk("active_hold", 32'(bus_if.active_id), 32'(last_act));
            end
            if (bus_if.done !== '0) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(bus_if.done), 32'd0);
                end else begin
                    m_eid = done_q.pop_front();
                    chk("done_onehot", 32'(bus_if.done), 32'(N'(1) << m_eid));
                    outstanding = 1'b0;
                    acks = acks + 16'd1;
                    chk("msg_count", 32'(bus_if.msg_count), 32'(acks));
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (incoming[i]) begin
                    model_full[i] = 1'b1;
                    model_data[i] = inc_data[i];
                    incoming[i]   = 1'b0;
                end
            end
            chk("req_ready", 32'(bus_if.req_ready), 32'(N'(~model_full)));
        end
    end

    // Requester driver: random offers when enabled, otherwise replays directed values
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (drive_en && !rst) begin
                drv_v = '0;
                for (int i = 0; i < int'(N); i++) begin
                    if (!model_full[i] && !incoming[i] && $urandom_range(0, 99) < 40) begin
                        drv_v[i] = 1'b1;
                        drv_d    = DW'($urandom);
                        bus_if.req_data[i*DW +: DW] = drv_d;
                        incoming[i] = 1'b1;
                        inc_data[i] = drv_d;
                    end
                end
                bus_if.req_valid = drv_v;
            end else begin
                bus_if.req_valid = dir_valid;
                bus_if.req_data  = dir_data;
            end
        end
    end

    // Bus model: busy rises the cycle after send and stays high for bus_hold cycles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus_phase = 0;
                bus_if.cdc_busy = 1'b0;
            end else if (bus_manual) begin
                bus_if.cdc_busy = man_busy;
            end else begin
                case (bus_phase)
                    0: if (bus_if.cdc_send === 1'b1) bus_phase = 1;
                    1: begin
                        bus_if.cdc_busy = 1'b1;
                        bus_cnt   = (bus_hold == 0) ? int'($urandom_range(1, 6)) : bus_hold;
                        bus_phase = 2;
                    end
                    default: begin
                        if (bus_cnt <= 1) begin
                            bus_if.cdc_busy = 1'b0;
                            bus_phase = 0;
                        end else begin
                            bus_cnt--;
                        end
                    end
                endcase
            end
        end
    end

    task automatic offer(input logic [N-1:0] mask, input logic [N*DW-1:0] data);
        @(negedge clk);
        #1;
        dir_valid = mask;
        dir_data  = data;
        for (int i = 0; i < int'(N); i++) begin
            if (mask[i]) begin
                incoming[i] = 1'b1;
                inc_data[i] = data[i*DW +: DW];
            end
        end
        @(negedge clk);
        #1;
        dir_valid = '0;
    endtask

    task automatic wait_send(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus_if.cdc_send === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (!outstanding && model_full == '0 && incoming == '0 &&
                bus_if.cdc_busy === 1'b0 && bus_if.cdc_send === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b0;
        dir_valid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.err_clr = 1'b0;
        dir_valid = '0;
        dir_data  = '0;
        drive_en = 1'b0; bus_manual = 1'b0; man_busy = 1'b0; bus_hold = 0; mon_en = 1'b0;
        rr_exp = '{8'h01, 8'h42, 8'h83, 8'hC4};
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus_if.req_ready), 32'hF);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_send", 32'(bus_if.cdc_send), 32'd0);
        chk("rst_data", 32'(bus_if.cdc_data), 32'd0);
        chk("rst_active", 32'(bus_if.active_id), 32'd0);
        chk("rst_err", 32'(bus_if.err_timeout), 32'd0);
        chk("rst_count", 32'(bus_if.msg_count), 32'd0);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Single send from requester 2
        bus_hold = 3;
        offer(4'b0100, 24'h15 << 12);
        @(negedge clk);
        chk("single_latency", 32'(bus_if.cdc_send), 32'd1);
        wait_idle("single_idle");
        chk("single_count", 32'(bus_if.msg_count), 32'd1);
        chk("single_word", 32'(send_log.size() > 0 ? send_log[0] : 8'h00), 32'h95);

        // Round robin from reset with all slots filled together
        do_reset();
        offer(4'b1111, {6'h04, 6'h03, 6'h02, 6'h01});
        wait_idle("rr_idle");
        chk("rr_len", 32'(send_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("rr_order", 32'(send_log.size() > i ? send_log[i] : 8'h00), 32'(rr_exp[i]));
        chk("rr_count", 32'(bus_if.msg_count), 32'd4);

        // Refill requester 0 while its first message is in flight
        bus_hold = 5;
        offer(4'b0001, 24'h0A);
        wait_send("refill_send1");
        chk("refill_ready_in_send", 32'(bus_if.req_ready[0]), 32'd1);
        offer(4'b0001, 24'h0B);
        wait_idle("refill_idle");
        chk("refill_last", 32'(send_log[$]), 32'h0B);

        // Stale busy in IDLE blocks grants
        @(negedge clk); #1;
        man_busy = 1'b1; bus_manual = 1'b1;
        repeat (2) @(negedge clk);
        offer(4'b0010, 24'h2A << 6);
        repeat (6) begin
            @(negedge clk);
            chk("stale_no_send", 32'(bus_if.cdc_send), 32'd0);
        end
        #1; man_busy = 1'b0;
        @(posedge clk); #2; bus_manual = 1'b0;
        wait_idle("stale_idle");

        // Randomized traffic
        bus_hold = 0;
        @(posedge clk); #2; drive_en = 1'b1;
        repeat (600) @(posedge clk);
        #2; drive_en = 1'b0; dir_valid = '0;
        wait_idle("rand_idle");
        chk("rand_no_err", 32'(bus_if.err_timeout), 32'd0);

        // Stuck acknowledge
        bus_hold = 300;
        offer(4'b1000, 24'h3C << 18);
        wait_send("stuck_send");
        offer(4'b0001, 24'h11);
        repeat (247) @(negedge clk);
        chk("stuck_err_early", 32'(bus_if.err_timeout), 32'd0);
        repeat (10) @(negedge clk);
        chk("stuck_err_set", 32'(bus_if.err_timeout), 32'd1);
        #1; bus_if.err_clr = 1'b1;
        @(negedge clk); #1; bus_if.err_clr = 1'b0;
        @(negedge clk);
        chk("stuck_err_clr", 32'(bus_if.err_timeout), 32'd0);
        bus_hold = 0;
        wait_idle("stuck_idle");
        chk("stuck_err_after", 32'(bus_if.err_timeout), 32'd0);

        // Reset while BUSY with two slots full
        bus_hold = 20;
        offer(4'b0010, 24'h07 << 6);
        wait_send("rstmid_send");
        offer(4'b0101, 24'h09);
        repeat (3) @(negedge clk);
        #1; rst = 1'b1; mon_en = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", 32'(bus_if.req_ready), 32'hF);
        chk("rstmid_send", 32'(bus_if.cdc_send), 32'd0);
        chk("rstmid_count", 32'(bus_if.msg_count), 32'd0);
        chk("rstmid_done", 32'(bus_if.done), 32'd0);
        #1; model_reset();
        @(negedge clk); #1; rst = 1'b0; mon_en = 1'b1;
        repeat (30) @(negedge clk);
        bus_hold = 2;
        offer(4'b0100, 24'h01 << 12);
        wait_idle("rstmid_idle");

        // Counter wrap
        @(negedge clk); #1;
        force dut.msg_count_r = 16'hFFFE;
        @(negedge clk); #1;
        release dut.msg_count_r;
        acks = 16'hFFFE;
        @(negedge clk);
        chk("wrap_preload", 32'(bus_if.msg_count), 32'hFFFE);
        offer(4'b0100, 24'h05 << 12);
        wait_idle("wrap_idle1");
        chk("wrap_ffff", 32'(bus_if.msg_count), 32'hFFFF);
        offer(4'b1000, 24'h06 << 18);
        wait_idle("wrap_idle2");
        chk("wrap_zero", 32'(bus_if.msg_count), 32'h0000);

        chk("final_pending_done", 32'(done_q.size()), 32'd0);
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
